// File: rtl/uart_avm_arbiter.sv
// Round-robin arbiter sharing the UART core's Avalon-MM slave port between the
// image loader (m0, read-only) and the result sender (m1, read/write).
module uart_avm_arbiter #(
    parameter int ADDR_W      = 5,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              avm_clk,
    input  logic              avm_rst,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_waitrequest,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_waitrequest,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    output logic              timeout
);

    // state | meaning
    // IDLE  | no owner; slave outputs zero, both masters stalled, arbitrate
    // BUSY  | r_grant owns the slave until completion, abort or timeout
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Counter only needs to reach TIMEOUT_CYC-1; it saturates at all-ones.
    localparam int             TW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0]  TC_LAST = TW'(TIMEOUT_CYC - 1);
    localparam bit             TO_EN   = (TIMEOUT_CYC != 0);

    logic [0:0]    r_state;
    logic          r_grant;
    logic          r_prio;
    logic [TW-1:0] r_tcnt;
    logic          r_timeout;

    logic w_m0_req;
    logic w_m1_req;
    logic w_m1_rd;
    logic w_busy;
    logic w_gnt_req;
    logic w_done;
    logic w_tout;
    logic w_next_gnt;

    // A simultaneous m1 read+write is treated as a write.
    assign w_m0_req   = m0_read;
    assign w_m1_req   = m1_read | m1_write;
    assign w_m1_rd    = m1_read & ~m1_write;
    assign w_busy     = (r_state == ST_BUSY);
    assign w_gnt_req  = r_grant ? w_m1_req : w_m0_req;
    assign w_done     = w_busy && w_gnt_req && !avm_waitrequest;
    assign w_tout     = TO_EN && w_busy && w_gnt_req && avm_waitrequest && (r_tcnt == TC_LAST);
    assign w_next_gnt = (w_m0_req && w_m1_req) ? r_prio : w_m1_req;

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= 1'b0;
            r_prio    <= 1'b0;
            r_tcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_tout;
            case (r_state)
                ST_IDLE: begin
                    if (w_m0_req || w_m1_req) begin
                        r_state <= ST_BUSY;
                        r_grant <= w_next_gnt;
                        r_tcnt  <= '0;
                    end
                end
                ST_BUSY: begin
                    // An abort leaves prio alone; completion and timeout hand it over.
                    if (!w_gnt_req) begin
                        r_state <= ST_IDLE;
                    end else if (w_done || w_tout) begin
                        r_state <= ST_IDLE;
                        r_prio  <= ~r_grant;
                    end else if (r_tcnt != '1) begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        avm_address   = '0;
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_writedata = '0;
        if (w_busy) begin
            if (r_grant) begin
                avm_address   = m1_address;
                avm_read      = w_m1_rd;
                avm_write     = m1_write;
                avm_writedata = m1_writedata;
            end else begin
                avm_address   = m0_address;
                avm_read      = m0_read;
            end
        end
    end

    assign m0_waitrequest = !(w_busy && !r_grant) || avm_waitrequest;
    assign m1_waitrequest = !(w_busy && r_grant) || avm_waitrequest;
    assign m0_readdata    = avm_readdata;
    assign m1_readdata    = avm_readdata;
    assign timeout        = r_timeout;

endmodule

// File: tb/tb_uart_avm_arbiter.sv
// Self-checking bench for uart_avm_arbiter: directed scenarios plus randomized
// single transactions checked against a transaction-level round-robin model.
module tb_uart_avm_arbiter;

    localparam int TOUT = 4;

    logic        avm_clk;
    logic        avm_rst;
    logic [4:0]  m0_address;
    logic        m0_read;
    logic [31:0] m0_readdata;
    logic        m0_waitrequest;
    logic [4:0]  m1_address;
    logic        m1_read;
    logic        m1_write;
    logic [31:0] m1_writedata;
    logic [31:0] m1_readdata;
    logic        m1_waitrequest;
    logic [4:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        timeout;

    int   n_checks = 0;
    int   n_errors = 0;
    logic mp;   // model: master that wins when both request

    uart_avm_arbiter #(.ADDR_W(5), .DATA_W(32), .TIMEOUT_CYC(TOUT)) dut (
        .avm_clk        (avm_clk),
        .avm_rst        (avm_rst),
        .m0_address     (m0_address),
        .m0_read        (m0_read),
        .m0_readdata    (m0_readdata),
        .m0_waitrequest (m0_waitrequest),
        .m1_address     (m1_address),
        .m1_read        (m1_read),
        .m1_write       (m1_write),
        .m1_writedata   (m1_writedata),
        .m1_readdata    (m1_readdata),
        .m1_waitrequest (m1_waitrequest),
        .avm_address    (avm_address),
        .avm_read       (avm_read),
        .avm_write      (avm_write),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .timeout        (timeout)
    );

    initial avm_clk = 1'b0;
    always #5 avm_clk = ~avm_clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drop_all();
        m0_read = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
        avm_waitrequest = 1'b1;
    endtask

    // One arbitration from IDLE: slave stalls w cycles; w >= TOUT means timeout.
    task automatic do_txn(input bit r0, input bit r1, input int op1,
                          input logic [4:0] a0, input logic [4:0] a1,
                          input logic [31:0] wd, input logic [31:0] rd, input int w);
        int          own;
        int          lim;
        bit          er;
        bit          ew;
        logic [4:0]  ea;
        logic [31:0] ewd;
        own = (r0 && r1) ? int'(mp) : (r1 ? 1 : 0);
        er  = (own == 0) ? 1'b1 : (op1 == 0);
        ew  = (own == 1) && (op1 != 0);
        ea  = (own == 1) ? a1 : a0;
        ewd = (own == 1) ? wd : 32'h0;
        lim = (w < TOUT) ? w : TOUT - 1;
        m0_read = r0; m0_address = a0;
        m1_read = r1 && (op1 != 1); m1_write = r1 && (op1 != 0);
        m1_address = a1; m1_writedata = wd;
        avm_waitrequest = 1'b1; avm_readdata = 32'h0;
        @(negedge avm_clk);
        chk("idle_m0_wait", m0_waitrequest, 1);
        chk("idle_m1_wait", m1_waitrequest, 1);
        chk("idle_rw", {avm_read, avm_write}, 0);
        chk("idle_addr", avm_address, 0);
        @(posedge avm_clk); #1;
        for (int k = 0; k <= lim; k++) begin
            avm_waitrequest = (k < w);
            avm_readdata = rd;
            @(negedge avm_clk);
            chk("bsy_read", avm_read, er);
            chk("bsy_write", avm_write, ew);
            chk("bsy_addr", avm_address, ea);
            chk("bsy_wdata", avm_writedata, ewd);
            chk("bsy_own_wait", (own == 1) ? m1_waitrequest : m0_waitrequest, (k < w));
            chk("bsy_oth_wait", (own == 1) ? m0_waitrequest : m1_waitrequest, 1);
            chk("bsy_tout", timeout, 0);
            if (k >= w && er)
                chk("bsy_rdata", (own == 1) ? m1_readdata : m0_readdata, rd);
            @(posedge avm_clk); #1;
        end
        mp = (own == 0);
        drop_all();
        @(negedge avm_clk);
        chk("end_tout", timeout, (w >= TOUT));
        chk("end_waits", {m0_waitrequest, m1_waitrequest}, 2'b11);
        @(posedge avm_clk); #1;
    endtask

    // Both masters request back to back with a zero-wait slave.
    task automatic run_stream(input int n);
        int          last_c;
        int          nd;
        int          cnt0;
        int          cnt1;
        int          own;
        bit          upd;
        logic [31:0] rd;
        logic [31:0] wd;
        wd = 32'h5A; last_c = -1; nd = 0; cnt0 = 0; cnt1 = 0;
        m0_read = 1'b1; m0_address = 5'h08;
        m1_read = 1'b0; m1_write = 1'b1; m1_address = 5'h04; m1_writedata = wd;
        avm_waitrequest = 1'b0; rd = $urandom; avm_readdata = rd;
        for (int c = 0; c < 4 * n + 8 && nd < n; c++) begin
            upd = 1'b0;
            @(negedge avm_clk);
            if (!m0_waitrequest || !m1_waitrequest) begin
                own = m1_waitrequest ? 0 : 1;
                chk("str_one_owner", (!m0_waitrequest && !m1_waitrequest), 0);
                chk("str_owner", own, mp);
                chk("str_gap", c - last_c, 2);
                if (own == 0) begin
                    chk("str_rdata", m0_readdata, rd);
                    chk("str_addr0", avm_address, 5'h08);
                    cnt0++;
                end else begin
                    chk("str_wdata", avm_writedata, wd);
                    chk("str_addr1", avm_address, 5'h04);
                    cnt1++;
                    upd = 1'b1;
                end
                mp = (own == 0);
                last_c = c;
                nd++;
            end
            chk("str_write", avm_write, !m1_waitrequest);
            chk("str_read", avm_read, !m0_waitrequest);
            @(posedge avm_clk); #1;
            if (upd) begin
                wd = wd + 32'h11;
                m1_writedata = wd;
            end
            rd = $urandom; avm_readdata = rd;
        end
        chk("str_done", nd, n);
        chk("str_cnt0", cnt0, n / 2);
        chk("str_cnt1", cnt1, n / 2);
        drop_all();
        @(posedge avm_clk); #1;
    endtask

    initial begin
        bit          r0;
        bit          r1;
        avm_rst = 1'b1; mp = 1'b0;
        m0_address = '0; m1_address = '0; m1_writedata = '0; avm_readdata = '0;
        drop_all();

        @(negedge avm_clk);
        chk("rst_m0_wait", m0_waitrequest, 1);
        chk("rst_m1_wait", m1_waitrequest, 1);
        chk("rst_rw", {avm_read, avm_write}, 0);
        chk("rst_addr", avm_address, 0);
        chk("rst_tout", timeout, 0);
        @(posedge avm_clk); #1;
        avm_rst = 1'b0;

        // Both request at reset exit: m0 first, then m1 write 0x5A to 0x04.
        run_stream(2);
        // Continuous contention: strict alternation, 4 each.
        run_stream(8);

        // m0 STATUS poll, zero-wait slave returning 0x80.
        do_txn(1'b1, 1'b0, 0, 5'h08, 5'h00, 32'h0, 32'h80, 0);
        // m1 read+write together is a write.
        do_txn(1'b0, 1'b1, 2, 5'h00, 5'h04, 32'hC3, 32'h0, 1);

        // Timeout on a stalled m1 write while m0 waits.
        m1_write = 1'b1; m1_address = 5'h04; m1_writedata = 32'h33;
        avm_waitrequest = 1'b1;
        @(negedge avm_clk);
        @(posedge avm_clk); #1;
        m0_read = 1'b1; m0_address = 5'h08;
        for (int k = 0; k < TOUT; k++) begin
            @(negedge avm_clk);
            chk("to_write", avm_write, 1);
            chk("to_m1_wait", m1_waitrequest, 1);
            chk("to_m0_wait", m0_waitrequest, 1);
            chk("to_pulse_early", timeout, 0);
            @(posedge avm_clk); #1;
        end
        @(negedge avm_clk);
        chk("to_pulse", timeout, 1);
        chk("to_idle_rw", {avm_read, avm_write}, 0);
        chk("to_m1_wait_idle", m1_waitrequest, 1);
        @(posedge avm_clk); #1;
        avm_waitrequest = 1'b0; avm_readdata = 32'h77;
        @(negedge avm_clk);
        chk("to_m0_read", avm_read, 1);
        chk("to_m0_addr", avm_address, 5'h08);
        chk("to_m0_wait", m0_waitrequest, 0);
        chk("to_m0_rdata", m0_readdata, 32'h77);
        chk("to_m1_wait_m0", m1_waitrequest, 1);
        chk("to_pulse_once", timeout, 0);
        @(posedge avm_clk); #1;
        m0_read = 1'b0;
        @(negedge avm_clk);
        chk("to_bubble", m1_waitrequest, 1);
        @(posedge avm_clk); #1;
        @(negedge avm_clk);
        chk("to_m1_done", m1_waitrequest, 0);
        chk("to_m1_wdata", avm_writedata, 32'h33);
        @(posedge avm_clk); #1;
        mp = 1'b0;
        drop_all();
        @(posedge avm_clk); #1;

        // Granted master drops its request: slave strobes go low, prio kept.
        m0_read = 1'b1; m0_address = 5'h08; avm_waitrequest = 1'b1;
        @(negedge avm_clk);
        @(posedge avm_clk); #1;
        @(negedge avm_clk);
        chk("ab_read", avm_read, 1);
        @(posedge avm_clk); #1;
        m0_read = 1'b0;
        @(negedge avm_clk);
        chk("ab_rw", {avm_read, avm_write}, 0);
        @(posedge avm_clk); #1;
        do_txn(1'b1, 1'b1, 1, 5'h08, 5'h04, 32'h21, 32'h12, 0);

        // Reset while the slave is stalled; prio returns to m0.
        do_txn(1'b1, 1'b0, 0, 5'h08, 5'h00, 32'h0, 32'h11, 0);
        m0_read = 1'b1; m0_address = 5'h08; avm_waitrequest = 1'b1;
        @(negedge avm_clk);
        @(posedge avm_clk); #1;
        @(negedge avm_clk);
        chk("rs_pre_read", avm_read, 1);
        @(posedge avm_clk); #1;
        avm_rst = 1'b1;
        @(negedge avm_clk);
        chk("rs_rw", {avm_read, avm_write}, 0);
        chk("rs_waits", {m0_waitrequest, m1_waitrequest}, 2'b11);
        chk("rs_tout", timeout, 0);
        @(posedge avm_clk); #1;
        avm_rst = 1'b0; mp = 1'b0;
        do_txn(1'b1, 1'b1, 1, 5'h00, 5'h04, 32'h9, 32'h44, 0);

        for (int i = 0; i < 40; i++) begin
            r0 = 1'($urandom_range(0, 1));
            r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
            do_txn(r0, r1, int'($urandom_range(0, 2)), 5'($urandom), 5'($urandom),
                   $urandom, $urandom, int'($urandom_range(0, 5)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
